agc_gain_apply: RTL

AGC_GAIN_APPLY -- requirements
Module: agc_gain_apply

---
 rtl/agc_pkg.sv | 9 +
 rtl/agc_level_detector.sv | 53 +++++
 rtl/agc_gain_apply.sv | 124 ++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Constants shared by the AGC error block and the AGC gain-apply block.
package agc_pkg;

  localparam int unsigned AGC_GFRAC      = 14;
  localparam int unsigned AGC_UNITY_GAIN = 1 << AGC_GFRAC;
  localparam int unsigned AGC_LOG2_WIN   = 6;
  localparam int unsigned AGC_LWIDTH     = 30;

endpackage

// File: rtl/agc_level_detector.sv
// Windowed mean-magnitude detector: averages |sample| over 2^LOG2_WIN valid samples.
module agc_level_detector
  import agc_pkg::*;
#(
  parameter int unsigned DINWIDTH = 16,
  parameter int unsigned LOG2_WIN = AGC_LOG2_WIN,
  parameter int unsigned LWIDTH   = AGC_LWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DINWIDTH-1:0] sample,
  input  logic                       valid,
  output logic        [LWIDTH-1:0]   level,
  output logic                       strobe
);

  localparam int unsigned AW = DINWIDTH + LOG2_WIN;

  logic [DINWIDTH-1:0] mag_c;
  logic [AW-1:0]       sum_c;
  logic [AW-1:0]       acc_q;
  logic [LOG2_WIN-1:0] cnt_q;

  // Magnitude fits unsigned DINWIDTH bits, so the most negative input maps to 2^(DINWIDTH-1).
  always_comb begin
    mag_c = sample[DINWIDTH-1] ? DINWIDTH'(-sample) : DINWIDTH'(sample);
    sum_c = acc_q + AW'(mag_c);
  end

  // Accumulate a full window; the closing sample publishes the mean and restarts the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      level  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (valid) begin
        if (cnt_q == '1) begin
          level  <= LWIDTH'(sum_c[AW-1:LOG2_WIN]);
          strobe <= 1'b1;
          acc_q  <= '0;
          cnt_q  <= '0;
        end else begin
          acc_q  <= sum_c;
          cnt_q  <= cnt_q + LOG2_WIN'(1);
        end
      end
    end
  end

endmodule

// File: rtl/agc_gain_apply.sv
// AGC gain stage: clamps the error word to a gain, applies it with rounding/saturation,
// and reports the output level back to the error block.
module agc_gain_apply
  import agc_pkg::*;
#(
  parameter int unsigned DINWIDTH = 16,
  parameter int unsigned ERRWIDTH = 48,
  parameter int unsigned GWIDTH   = 18,
  parameter int unsigned GFRAC    = AGC_GFRAC,
  parameter int unsigned GSHIFT   = 20,
  parameter int unsigned LOG2_WIN = AGC_LOG2_WIN,
  parameter int unsigned LWIDTH   = AGC_LWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DINWIDTH-1:0] Data_In,
  input  logic                       Valid_In,
  input  logic signed [ERRWIDTH-1:0] Gain_In,
  input  logic                       Gain_Valid,
  output logic signed [DINWIDTH-1:0] Data_Out,
  output logic                       Valid_Out,
  output logic                       Sat_Out,
  output logic        [LWIDTH-1:0]   Level_Out,
  output logic                       Level_Valid
);

  localparam int unsigned PW = DINWIDTH + GWIDTH + 1;
  localparam int unsigned SW = PW - GFRAC;
  localparam logic [GWIDTH-1:0]          UNITY = GWIDTH'(1) << GFRAC;
  localparam logic signed [PW-1:0]       RND   = PW'(1) << (GFRAC - 1);
  localparam logic signed [DINWIDTH-1:0] SMAX  = {1'b0, {(DINWIDTH-1){1'b1}}};
  localparam logic signed [DINWIDTH-1:0] SMIN  = {1'b1, {(DINWIDTH-1){1'b0}}};

  logic signed [ERRWIDTH-1:0] gain_shift_c;
  logic        [GWIDTH-1:0]   gain_clamp_c;
  logic        [GWIDTH-1:0]   gain_q;
  logic signed [PW-1:0]       prod_c;
  logic signed [PW-1:0]       prod_q;
  logic signed [SW-1:0]       scaled_q;
  logic                       v1_q;
  logic                       v2_q;
  logic                       ovf_c;

  // Extract the gain from the error word and clamp it to [0, 2^GWIDTH-1].
  always_comb begin
    gain_shift_c = Gain_In >>> GSHIFT;
    gain_clamp_c = gain_shift_c[GWIDTH-1:0];
    if (gain_shift_c[ERRWIDTH-1]) begin
      gain_clamp_c = '0;
    end else if (|gain_shift_c[ERRWIDTH-2:GWIDTH]) begin
      gain_clamp_c = '1;
    end
  end

  // Gain register; a sample accepted on the update edge still multiplies by the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain_q <= UNITY;
    end else if (Gain_Valid) begin
      gain_q <= gain_clamp_c;
    end
  end

  // Signed sample times zero-extended gain, full precision.
  assign prod_c = PW'(Data_In) * PW'($signed({1'b0, gain_q}));

  // Stage 1 registers the product so it maps onto one multiplier block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q   <= Valid_In;
      prod_q <= prod_c;
    end
  end

  // Stage 2: round half up and drop the fractional bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      scaled_q <= '0;
    end else begin
      v2_q     <= v1_q;
      scaled_q <= SW'((prod_q + RND) >>> GFRAC);
    end
  end

  // Overflow when the bits above the output sign are not all copies of it.
  assign ovf_c = !((&scaled_q[SW-1:DINWIDTH-1]) || !(|scaled_q[SW-1:DINWIDTH-1]));

  // Stage 3: saturate; data and flag hold while no sample is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Valid_Out <= 1'b0;
      Data_Out  <= '0;
      Sat_Out   <= 1'b0;
    end else begin
      Valid_Out <= v2_q;
      if (v2_q) begin
        Sat_Out <= ovf_c;
        if (ovf_c) begin
          Data_Out <= scaled_q[SW-1] ? SMIN : SMAX;
        end else begin
          Data_Out <= scaled_q[DINWIDTH-1:0];
        end
      end
    end
  end

  agc_level_detector #(
    .DINWIDTH (DINWIDTH),
    .LOG2_WIN (LOG2_WIN),
    .LWIDTH   (LWIDTH)
  ) u_level (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (Data_Out),
    .valid  (Valid_Out),
    .level  (Level_Out),
    .strobe (Level_Valid)
  );

endmodule
